// File: rtl/dense_frame_loader.sv
// Serial-to-parallel frame loader for the 20x6-bit dense classifier, double-buffered
// with framing checks. Define DENSE_LOADER_CNT_EN to add frame_cnt/drop_cnt outputs.
module dense_frame_loader #(
  parameter int NUM_FEAT = 20,
  parameter int FEAT_W   = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [FEAT_W-1:0]          s_data,
  input  logic                       s_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [NUM_FEAT*FEAT_W-1:0] m_feat,
  output logic                       frame_err
`ifdef DENSE_LOADER_CNT_EN
  ,
  output logic [15:0]                frame_cnt,
  output logic [15:0]                drop_cnt
`endif
);
  localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

  typedef enum logic [1:0] {FILL, DROP, COMMIT} state_t;

  state_t                              state_q, state_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic [NUM_FEAT-1:0][FEAT_W-1:0]     fill_q, fill_d;
  logic [NUM_FEAT-1:0][FEAT_W-1:0]     out_q, out_d;
  logic                                m_valid_q, m_valid_d;
  logic                                err_q, err_d;

  logic             commit_ok, commit, fill_act, acc;
  logic [IDX_W-1:0] cur_idx;

  // State register (all flops)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FILL;
      idx_q     <= '0;
      fill_q    <= '0;
      out_q     <= '0;
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      fill_q    <= fill_d;
      out_q     <= out_d;
      m_valid_q <= m_valid_d;
      err_q     <= err_d;
    end
  end

  // Output/control decode. A committing cycle also accepts a beat, which
  // becomes slot 0 of the next frame so back-to-back streams lose nothing.
  always_comb begin
    commit_ok = !m_valid_q || m_ready;
    commit    = (state_q == COMMIT) && commit_ok;
    fill_act  = (state_q == FILL) || commit;
    s_ready   = rst_n && ((state_q != COMMIT) || commit_ok);
    acc       = s_valid && s_ready;
    cur_idx   = (state_q == COMMIT) ? '0 : idx_q;
    m_valid   = m_valid_q;
    m_feat    = out_q;
    frame_err = err_q;
  end

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = 1'b0;
    fill_d    = fill_q;
    out_d     = commit ? fill_q : out_q;
    m_valid_d = commit ? 1'b1 : ((m_valid_q && m_ready) ? 1'b0 : m_valid_q);
    case (state_q)
      COMMIT: if (commit_ok) begin
        state_d = FILL;
        idx_d   = '0;
      end
      DROP: if (acc && s_last) begin
        state_d = FILL;
        idx_d   = '0;
      end
      default: ;
    endcase
    if (fill_act && acc) begin
      fill_d[cur_idx] = s_data;
      if (cur_idx == LAST_IDX) begin
        idx_d = '0;
        if (s_last) begin
          state_d = COMMIT;
        end else begin
          state_d = DROP;
          err_d   = 1'b1;
        end
      end else if (s_last) begin
        state_d = FILL;
        idx_d   = '0;
        err_d   = 1'b1;
      end else begin
        idx_d = cur_idx + 1'b1;
      end
    end
  end

`ifdef DENSE_LOADER_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;

  always_comb begin
    frame_cnt_d = commit ? frame_cnt_q + 16'd1 : frame_cnt_q;
    drop_cnt_d  = err_d ? drop_cnt_q + 16'd1 : drop_cnt_q;
    frame_cnt   = frame_cnt_q;
    drop_cnt    = drop_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_dense_frame_loader.sv
// Scoreboard bench for dense_frame_loader: directed frames push expected vectors,
// a negedge monitor pops and compares on every consumed output frame.
module tb_dense_frame_loader;
  localparam int NF = 20;
  localparam int FW = 6;

  logic              clk = 1'b0;
  logic              rst_n, s_valid, s_last, m_ready;
  logic [FW-1:0]     s_data;
  logic              s_ready, m_valid, frame_err;
  logic [NF*FW-1:0]  m_feat;
`ifdef DENSE_LOADER_CNT_EN
  logic [15:0]       frame_cnt, drop_cnt;
`endif

  dense_frame_loader #(.NUM_FEAT(NF), .FEAT_W(FW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_feat(m_feat), .frame_err(frame_err)
`ifdef DENSE_LOADER_CNT_EN
    , .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int err_seen = 0;
  int err_exp = 0;
  int exp_frames = 0;
  int exp_drop = 0;
  logic [NF*FW-1:0] exp_q[$];

  task automatic chkv(input string nm, input logic [NF*FW-1:0] act, input logic [NF*FW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Monitor: every frame the consumer takes must match the scoreboard head
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) err_seen++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got %h want none", m_feat);
        end else begin
          chkv("frame", m_feat, exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [FW-1:0] d, input logic l);
    int n;
    bit done;
    n = 0;
    done = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!done) begin
      @(negedge clk);
      done = s_ready;
      tick();
      n++;
      if (!done && n > 200) begin
        total++;
        bad++;
        $display("FAIL beat_timeout: got s_ready=0 for %0d cycles want 1", n);
        done = 1;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  function automatic logic [FW-1:0] vgen(input int mode, input logic [FW-1:0] base, input int k);
    logic [FW-1:0] kk;
    kk = FW'(k);
    case (mode)
      1:       return base + kk;
      2:       return base - kk;
      default: return base;
    endcase
  endfunction

  // nb beats, s_last on the final one; only well-formed frames are expected out
  task automatic send_frame(input int nb, input int mode, input logic [FW-1:0] base, input bit push);
    logic [NF*FW-1:0] f;
    logic [FW-1:0] v;
    f = '0;
    for (int k = 0; k < nb; k++) begin
      v = vgen(mode, base, k);
      if (k < NF) f[k*FW +: FW] = v;
      send_beat(v, k == nb - 1);
    end
    if (nb == NF) begin
      if (push) begin
        exp_q.push_back(f);
        exp_frames++;
      end
    end else begin
      err_exp++;
      exp_drop++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    m_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    repeat (2) tick();
    chkn("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NF*FW-1:0] fa, fb;
    fa = {NF{6'h3F}};
    fb = {NF{6'h01}};
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
    @(negedge clk);
    chkb("rst_s_ready", s_ready, 1'b0);
    chkb("rst_m_valid", m_valid, 1'b0);
    chkb("rst_frame_err", frame_err, 1'b0);
    chkv("rst_m_feat", m_feat, '0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chkb("post_rst_s_ready", s_ready, 1'b1);
    tick();

    // 1: ramp 0..19, latency and lane placement
    m_ready = 1'b1;
    send_frame(NF, 1, 6'd0, 1);
    @(negedge clk);
    chkb("t1_m_valid_commit_cycle", m_valid, 1'b0);
    tick();
    @(negedge clk);
    chkb("t1_m_valid_rise", m_valid, 1'b1);
    chkv("t1_x0", {114'b0, m_feat[5:0]}, {114'b0, 6'd0});
    chkv("t1_x19", {114'b0, m_feat[119:114]}, {114'b0, 6'd19});
    tick();
    @(negedge clk);
    chkb("t1_m_valid_fall", m_valid, 1'b0);
    chkn("t1_no_err", err_seen, 0);
    tick();

    // 2: back-to-back frames against a stalled consumer
    m_ready = 1'b0;
    send_frame(NF, 0, 6'h3F, 1);
    send_frame(NF, 0, 6'h01, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chkb("t2_hold_valid", m_valid, 1'b1);
      chkv("t2_hold_feat", m_feat, fa);
      chkb("t2_s_ready_blocked", s_ready, 1'b0);
      tick();
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    @(negedge clk);
    chkb("t2_swap_valid", m_valid, 1'b1);
    chkv("t2_swap_feat", m_feat, fb);
    tick();
    drain();

    // 3: short frame then a clean frame of 5s
    send_frame(8, 0, 6'd9, 0);
    @(negedge clk);
    chkb("t3_err_pulse", frame_err, 1'b1);
    chkb("t3_no_valid", m_valid, 1'b0);
    tick();
    @(negedge clk);
    chkb("t3_err_one_cycle", frame_err, 1'b0);
    tick();
    send_frame(NF, 0, 6'd5, 1);
    drain();
    chkn("t3_err_count", err_seen, err_exp);

    // 4: long frame of 25 beats, then a good frame
    send_frame(25, 1, 6'd0, 0);
    repeat (2) tick();
    chkn("t4_err_count", err_seen, err_exp);
    send_frame(NF, 2, 6'h3F, 1);
    drain();
`ifdef DENSE_LOADER_CNT_EN
    chkn("t4_drop_cnt", int'(drop_cnt), exp_drop);
`endif

    // 5: reset with a held frame and a partial frame in flight
    m_ready = 1'b0;
    send_frame(NF, 0, 6'h2A, 0);
    for (int k = 0; k < 10; k++) send_beat(FW'(k), 1'b0);
    @(negedge clk);
    chkb("t5_held_before_rst", m_valid, 1'b1);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chkb("t5_rst_s_ready", s_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    exp_frames = 0;
    exp_drop = 0;
    @(negedge clk);
    chkb("t5_rst_m_valid", m_valid, 1'b0);
    chkv("t5_rst_m_feat", m_feat, '0);
    tick();
    m_ready = 1'b1;
    send_frame(NF, 1, 6'd40, 1);
    drain();

    // 6: more good frames plus a short one for the counters
    send_frame(NF, 1, 6'd10, 1);
    send_frame(NF, 0, 6'd7, 1);
    send_frame(3, 0, 6'd1, 0);
    drain();
    chkn("final_err_count", err_seen, err_exp);
`ifdef DENSE_LOADER_CNT_EN
    chkn("t6_frame_cnt", int'(frame_cnt), exp_frames);
    chkn("t6_drop_cnt", int'(drop_cnt), exp_drop);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
